// File: rtl/uart_rx.sv
// uart_rx -- 8N1-style UART receiver.
//
// Oversamples the asynchronous serial line on tick_i (Oversample pulses per
// bit period, supplied by the shared baud generator). Each frame begins with
// a falling edge, which is checked again at the middle of the start bit.
// Data bits are then sampled at their centres, LSB first, and the stop bit
// is checked. Every received word is reported with a one-cycle pulse.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   tick_i       oversample enable, one clk wide
//   rxd_i        asynchronous serial input, idle high
//   data_o       last correctly framed word (held until the next good frame)
//   dv_o         one-cycle pulse: new word on data_o
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   busy_o       high while a frame is in progress
module uart_rx #(
  parameter int DataWidth  = 8,
  parameter int Oversample = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic                 rxd_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 dv_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(Oversample);
  localparam int BW = $clog2(DataWidth + 1);

  localparam logic [TW-1:0] TickMid  = TW'(Oversample / 2 - 1);
  localparam logic [TW-1:0] TickLast = TW'(Oversample - 1);
  localparam logic [TW-1:0] TickOne  = TW'(1);
  localparam logic [BW-1:0] BitLast  = BW'(DataWidth - 1);
  localparam logic [BW-1:0] BitOne   = BW'(1);

  typedef enum logic [1:0] {
    Idle,
    StartBit,
    DataBits,
    StopBit
  } state_t;

  state_t state, state_next;

  logic sync1, rxs, prev;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DataWidth-1:0] shift_reg;

  logic start_edge;
  logic stop_sample;
  logic dv_next;
  logic err_next;

  // Synchronizer and history flops reset high so that reset itself never
  // looks like a falling edge on an idle line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd_i;
      rxs   <= sync1;
      prev  <= rxs;
    end
  end

  // A start needs a genuine high-to-low transition, so a line stuck low
  // (break) cannot retrigger until it has gone high again.
  assign start_edge = prev & ~rxs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= Idle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      Idle: begin
        if (start_edge) state_next = StartBit;
      end
      StartBit: begin
        // Mid start bit: a line back high means the edge was a glitch.
        if (tick_i && tick_cnt == TickMid) state_next = rxs ? Idle : DataBits;
      end
      DataBits: begin
        if (tick_i && tick_cnt == TickLast && bit_cnt == BitLast) state_next = StopBit;
      end
      StopBit: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (tick_i && tick_cnt == TickLast) state_next = Idle;
      end
      default: state_next = Idle;
    endcase
  end

  always_comb begin
    stop_sample = (state == StopBit) && tick_i && (tick_cnt == TickLast);
    dv_next     = stop_sample & rxs;
    err_next    = stop_sample & ~rxs;
  end

  // Counters, shift register and registered outputs. The tick counter is
  // cleared on every state change, so each state counts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_o      <= '0;
      dv_o        <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (state == DataBits && tick_i && tick_cnt == TickLast) begin
        shift_reg <= {rxs, shift_reg[DataWidth-1:1]};
        bit_cnt   <= bit_cnt + BitOne;
      end
      if (state != state_next) begin
        tick_cnt <= '0;
        if (state_next == StartBit || state_next == DataBits) bit_cnt <= '0;
      end else if (tick_i && state != Idle) begin
        tick_cnt <= (tick_cnt == TickLast) ? '0 : tick_cnt + TickOne;
      end
      dv_o        <= dv_next;
      frame_err_o <= err_next;
      if (dv_next) data_o <= shift_reg;
      busy_o      <= (state_next != Idle);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx.
//
// A free-running process produces tick_i every tick_div clocks; the serial
// line is driven bit by bit in units of ticks. A negedge monitor counts dv_o,
// frame_err_o and overlapping pulses so that frame outcomes can be checked.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       rxd;
  logic [7:0] data;
  logic       dv;
  logic       ferr;
  logic       busy;

  int tick_div = 1;
  int n_asserts = 0;
  int n_fail = 0;
  int dv_count = 0;
  int ferr_count = 0;
  int both_count = 0;

  uart_rx #(
    .DataWidth(8),
    .Oversample(OS)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .tick_i(tick),
    .rxd_i(rxd),
    .data_o(data),
    .dv_o(dv),
    .frame_err_o(ferr),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample tick generator: one-clock pulse every tick_div clocks.
  initial begin
    int phase;
    phase = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = phase + 1;
      if (phase >= tick_div) begin
        phase = 0;
        tick = 1'b1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Output pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (dv === 1'b1) dv_count++;
    if (ferr === 1'b1) ferr_count++;
    if (dv === 1'b1 && ferr === 1'b1) both_count++;
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_ticks(OS);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    logic [7:0] partial;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_dv", dv, 1'b0);
    checkOutput("reset_ferr", ferr, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_ticks(32);

    // Plain frame 0xA5, tick every clock.
    $display("[TB] frame 0xA5");
    send_bit(1'b0);
    checkOutput("a5_busy_mid", busy, 1'b1);
    partial = 8'hA5;
    for (int i = 0; i < 8; i++) send_bit(partial[i]);
    send_bit(1'b1);
    wait_ticks(2);
    checkOutput("a5_dv_count", dv_count, 1);
    checkOutput("a5_data", data, 8'hA5);
    checkOutput("a5_ferr_count", ferr_count, 0);
    checkOutput("a5_busy_after", busy, 1'b0);

    // Short low glitch rejected at mid start bit.
    $display("[TB] glitch");
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    checkOutput("glitch_busy_high", busy, 1'b1);
    wait_ticks(12);
    checkOutput("glitch_busy_low", busy, 1'b0);
    checkOutput("glitch_dv_count", dv_count, 1);
    checkOutput("glitch_ferr_count", ferr_count, 0);
    checkOutput("glitch_data", data, 8'hA5);
    wait_ticks(16);
    applyStimulus(8'h3C, 1'b1);
    wait_ticks(2);
    checkOutput("glitch_next_dv", dv_count, 2);
    checkOutput("glitch_next_data", data, 8'h3C);

    // Good 0xA5 then 0x5A with a low stop bit.
    $display("[TB] framing error");
    applyStimulus(8'hA5, 1'b1);
    checkOutput("ferr_first_data", data, 8'hA5);
    applyStimulus(8'h5A, 1'b0);
    rxd = 1'b1;
    wait_ticks(16);
    checkOutput("ferr_count", ferr_count, 1);
    checkOutput("ferr_dv_count", dv_count, 3);
    checkOutput("ferr_data", data, 8'hA5);

    // Break: line low for 30 bit times.
    $display("[TB] break");
    rxd = 1'b0;
    wait_ticks(30 * OS);
    rxd = 1'b1;
    wait_ticks(32);
    checkOutput("break_ferr_count", ferr_count, 2);
    checkOutput("break_dv_count", dv_count, 3);
    checkOutput("break_busy", busy, 1'b0);
    checkOutput("break_data", data, 8'hA5);
    applyStimulus(8'h3C, 1'b1);
    wait_ticks(2);
    checkOutput("break_next_dv", dv_count, 4);
    checkOutput("break_next_data", data, 8'h3C);
    checkOutput("break_next_ferr", ferr_count, 2);

    // Back-to-back frames, tick every 3 clocks.
    $display("[TB] back-to-back");
    tick_div = 3;
    wait_ticks(16);
    applyStimulus(8'h00, 1'b1);
    checkOutput("b2b_first_dv", dv_count, 5);
    checkOutput("b2b_first_data", data, 8'h00);
    applyStimulus(8'hFF, 1'b1);
    wait_ticks(2);
    checkOutput("b2b_second_dv", dv_count, 6);
    checkOutput("b2b_second_data", data, 8'hFF);

    // Reset during data bit 4, then frame 0x81.
    $display("[TB] reset mid-frame");
    tick_div = 1;
    wait_ticks(16);
    partial = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rxd = partial[4];
    wait_ticks(8);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_data", data, 8'h00);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_dv", dv, 1'b0);
    checkOutput("rst_mid_ferr", ferr, 1'b0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(32);
    checkOutput("rst_after_dv", dv_count, 6);
    checkOutput("rst_after_busy", busy, 1'b0);
    applyStimulus(8'h81, 1'b1);
    wait_ticks(2);
    checkOutput("rst_next_dv", dv_count, 7);
    checkOutput("rst_next_data", data, 8'h81);
    checkOutput("rst_next_ferr", ferr_count, 2);

    checkOutput("dv_ferr_overlap", both_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
